// File: rtl/erm16_mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the ERM16 memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface erm16_mem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_done;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_done;
  logic [DW-1:0] rdata;
  logic          err;
  logic          owner;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, mem_ready,
    output cpu_done, dma_done, rdata, err, owner,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, mem_ready,
    input  cpu_done, dma_done, rdata, err, owner,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/erm16_mem_arbiter.sv
// Round-robin CPU/DMA arbiter for the single ERM16 memory port, with bounded DMA
// bursts and a wait-state timeout that aborts a stuck access.
//
// state    | meaning
// S_IDLE   | no transfer; arbitrate and latch the winner onto mem_*
// S_ACCESS | mem_en high, waiting for mem_ready or timeout
// S_RESP   | one-cycle done pulse (with err) to the owner
module erm16_mem_arbiter #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int DMA_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input logic               clk,
  input logic               rst,
  erm16_mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int BW = $clog2(DMA_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(DMA_BURST);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          last_owner;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic          pick_dma;

  // Contested: alternate, but let DMA keep the port for up to DMA_BURST grants.
  always_comb begin
    pick_dma = bus.dma_req;
    if (bus.cpu_req && bus.dma_req)
      pick_dma = !last_owner || (burst_cnt < BURST_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      last_owner    <= 1'b1;
      burst_cnt     <= BURST_MAX;
      wait_cnt      <= '0;
      bus.cpu_done  <= 1'b0;
      bus.dma_done  <= 1'b0;
      bus.rdata     <= '0;
      bus.err       <= 1'b0;
      bus.owner     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            state      <= S_ACCESS;
            bus.mem_en <= 1'b1;
            bus.owner  <= pick_dma;
            last_owner <= pick_dma;
            if (pick_dma) begin
              bus.mem_we    <= bus.dma_we;
              bus.mem_addr  <= bus.dma_addr;
              bus.mem_wdata <= bus.dma_wdata;
              burst_cnt     <= (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + BW'(1);
            end else begin
              bus.mem_we    <= bus.cpu_we;
              bus.mem_addr  <= bus.cpu_addr;
              bus.mem_wdata <= bus.cpu_wdata;
              burst_cnt     <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_ready || wait_cnt == WAIT_LAST) begin
            // Completion takes priority over a coincident timeout.
            if (bus.mem_ready && !bus.mem_we)
              bus.rdata <= bus.mem_rdata;
            bus.err      <= !bus.mem_ready;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.cpu_done <= !bus.owner;
            bus.dma_done <= bus.owner;
            state        <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_RESP: begin
          bus.cpu_done <= 1'b0;
          bus.dma_done <= 1'b0;
          bus.err      <= 1'b0;
          wait_cnt     <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_erm16_mem_arbiter.sv
// Directed and randomized bench for erm16_mem_arbiter against a transaction-level model.
module tb_erm16_mem_arbiter;
  localparam int DW = 16, AW = 16, BURST = 4, TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  erm16_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  erm16_mem_arbiter #(.DW(DW), .AW(AW), .DMA_BURST(BURST), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // model state
  int            ref_last;
  int            ref_burst;
  logic [DW-1:0] ref_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    {31'd0, bus.mem_en}, 0);
    check({tag, "_we"},    {31'd0, bus.mem_we}, 0);
    check({tag, "_addr"},  {16'd0, bus.mem_addr}, 0);
    check({tag, "_wd"},    {16'd0, bus.mem_wdata}, 0);
    check({tag, "_done"},  {30'd0, bus.cpu_done, bus.dma_done}, 0);
    check({tag, "_err"},   {31'd0, bus.err}, 0);
    check({tag, "_owner"}, {31'd0, bus.owner}, 0);
    check({tag, "_rdata"}, {16'd0, bus.rdata}, 0);
  endtask

  task automatic model_reset();
    ref_last  = 1;
    ref_burst = BURST;
    ref_rdata = '0;
  endtask

  // Called #1 after a rising edge while the DUT is idle. Runs one complete transfer.
  task automatic xfer(input bit c, input bit d, input bit hold, input int waits,
                      input bit rnd, input logic [DW-1:0] rdv, output bit got_owner);
    bit            w, tmo;
    int            n;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, rv;
    if (rnd) begin
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = AW'($urandom);
      bus.cpu_wdata = DW'($urandom);
      bus.dma_we    = 1'($urandom_range(0, 1));
      bus.dma_addr  = AW'($urandom);
      bus.dma_wdata = DW'($urandom);
    end
    bus.cpu_req = c;
    bus.dma_req = d;
    if (c && d) w = (ref_last == 0) ? 1'b1 : (ref_burst < BURST);
    else        w = d;
    ref_burst = w ? ((ref_burst < BURST) ? ref_burst + 1 : BURST) : 0;
    ref_last  = int'(w);
    e_we   = w ? bus.dma_we    : bus.cpu_we;
    e_addr = w ? bus.dma_addr  : bus.cpu_addr;
    e_wd   = w ? bus.dma_wdata : bus.cpu_wdata;
    tmo = (waits >= TO);
    n   = tmo ? TO : waits + 1;
    rv  = '0;
    got_owner = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) got_owner = bus.owner;
      check("acc_en",    {31'd0, bus.mem_en}, 1);
      check("acc_we",    {31'd0, bus.mem_we}, {31'd0, e_we});
      check("acc_addr",  {16'd0, bus.mem_addr}, {16'd0, e_addr});
      check("acc_wdata", {16'd0, bus.mem_wdata}, {16'd0, e_wd});
      check("acc_owner", {31'd0, bus.owner}, {31'd0, w});
      check("acc_done",  {30'd0, bus.cpu_done, bus.dma_done}, 0);
      check("acc_err",   {31'd0, bus.err}, 0);
      if (!hold) begin
        // the losing side may wiggle freely; it must not disturb this transfer
        if (w) begin bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_addr = AW'($urandom); end
        else   begin bus.dma_req = 1'($urandom_range(0, 1)); bus.dma_addr = AW'($urandom); end
      end
      bus.mem_ready = (i == waits);
      rv            = (i == waits) ? rdv : DW'($urandom);
      bus.mem_rdata = rv;
    end
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    if (!tmo && !e_we) ref_rdata = rv;
    check("resp_cpu_done", {31'd0, bus.cpu_done}, {31'd0, !w});
    check("resp_dma_done", {31'd0, bus.dma_done}, {31'd0, w});
    check("resp_err",      {31'd0, bus.err}, {31'd0, tmo});
    check("resp_rdata",    {16'd0, bus.rdata}, {16'd0, ref_rdata});
    check("resp_en",       {30'd0, bus.mem_en, bus.mem_we}, 0);
    if (!hold) begin
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
    end
    @(posedge clk); #1;
    check("idle_done", {30'd0, bus.cpu_done, bus.dma_done}, 0);
    check("idle_err",  {31'd0, bus.err}, 0);
    check("idle_en",   {31'd0, bus.mem_en}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
  endtask

  bit go;
  bit exp_order [11] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    model_reset();
    #1;
    check_reset_outputs("por");
    do_reset();

    // contested requests held continuously from reset
    for (int k = 0; k < 11; k++) begin
      xfer(1, 1, 1, $urandom_range(0, 2), 1, DW'($urandom), go);
      check("rr_order", {31'd0, go}, {31'd0, exp_order[k]});
    end
    bus.cpu_req = 0; bus.dma_req = 0;
    @(posedge clk); #1;

    // CPU read, zero wait
    bus.cpu_we = 0; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 16'h0;
    xfer(1, 0, 0, 0, 0, 16'hBEEF, go);
    check("t1_rdata", {16'd0, bus.rdata}, 32'h0000BEEF);

    // DMA write with three wait states
    bus.dma_we = 1; bus.dma_addr = 16'h1234; bus.dma_wdata = 16'h00FF;
    xfer(0, 1, 0, 3, 0, 16'h5A5A, go);
    check("t3_rdata_kept", {16'd0, bus.rdata}, 32'h0000BEEF);

    // timeout abort, then a normal transfer
    bus.cpu_we = 0; bus.cpu_addr = 16'h0002;
    xfer(1, 0, 0, TO + 3, 0, 16'h1111, go);
    xfer(1, 0, 0, 1, 0, 16'h2222, go);
    check("t4_recover", {16'd0, bus.rdata}, 32'h00002222);

    // ready coincident with the timeout cycle
    bus.dma_we = 0; bus.dma_addr = 16'h0777;
    xfer(0, 1, 0, TO - 1, 0, 16'hC0DE, go);
    check("t5_rdata", {16'd0, bus.rdata}, 32'h0000C0DE);

    // async reset in the middle of an access
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0ABC; bus.cpu_wdata = 16'h1357;
    repeat (3) @(posedge clk);
    #1;
    check("t6_pre_en", {31'd0, bus.mem_en}, 1);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("t6_async");
    bus.cpu_req = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t6_no_done", {30'd0, bus.cpu_done, bus.dma_done}, 0);
    end
    xfer(1, 1, 0, 0, 1, DW'($urandom), go);
    check("t6_cpu_first", {31'd0, go}, 0);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      int  sel;
      sel = $urandom_range(1, 3);
      xfer(sel[0], sel[1], 0, $urandom_range(0, TO + 1), 1, DW'($urandom), go);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
